// File: rtl/ram_scrambler_config_writer_pkg.sv
// Shared constants, state encoding and shadow payload for the scrambler config image.
package ram_scrambler_config_writer_pkg;

    localparam int unsigned ADDR_W             = 7;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned SEED_W             = 256;
    localparam int unsigned SEED_BYTES         = SEED_W / DATA_W;
    localparam int unsigned MODE_ADDR          = 0;
    localparam int unsigned SEED_ADDR_START    = 32;
    localparam int unsigned SEED_ADDR_END      = 64;
    localparam int unsigned MEM_SIZE           = 64;
    localparam int unsigned READ_DELAY_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    typedef struct packed {
        logic              mode;
        logic [SEED_W-1:0] seed;
    } cfg_t;

endpackage

// File: rtl/ram_scrambler_config_writer_image.sv
// Combinational map from (mode, seed, byte address) to the stored config image byte.
module ram_scrambler_config_writer_image
    import ram_scrambler_config_writer_pkg::*;
(
    input  logic              mode_i,
    input  logic [SEED_W-1:0] seed_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] byte_c
);

    logic [4:0] seed_idx;
    logic [4:0] byte_sel;

    always_comb begin
        seed_idx = 5'(addr_i - ADDR_W'(SEED_ADDR_START));
        // Seed byte 0 lives in the most significant byte of seed_i.
        byte_sel = 5'(SEED_BYTES - 1) - seed_idx;
        byte_c   = '0;
        if (addr_i == ADDR_W'(MODE_ADDR)) begin
            byte_c = {{(DATA_W-1){1'b0}}, mode_i};
        end else if (addr_i >= ADDR_W'(SEED_ADDR_START) && addr_i < ADDR_W'(SEED_ADDR_END)) begin
            byte_c = seed_i[{byte_sel, 3'b000} +: DATA_W];
        end
    end

endmodule

// File: rtl/ram_scrambler_config_writer.sv
// Writes the scrambler mode/seed image into the 64-byte config RAM and optionally
// reads it back through the registered RAM port, flagging any mismatch.
module ram_scrambler_config_writer
    import ram_scrambler_config_writer_pkg::*;
#(
    parameter int unsigned READ_DELAY = READ_DELAY_DEFAULT,
    parameter bit          VERIFY_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_in,
    input  logic [SEED_W-1:0] seed_in,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              verify_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
    // Compare index starts "negative" (wrapped) so bit ADDR_W-1 marks not-yet-valid q.
    localparam logic [ADDR_W-1:0] IDX_START = ADDR_W'(0) - ADDR_W'(READ_DELAY);

    state_e            state_q;
    cfg_t              cfg_q;
    cfg_t              wr_cfg_c;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] wr_byte_c;
    logic [DATA_W-1:0] exp_byte_c;
    logic              wren_q;
    logic              busy_q;
    logic              done_q;
    logic              verr_q;

    // Write data is registered, so the image is looked up for the address presented next.
    always_comb begin
        wr_cfg_c  = cfg_q;
        wr_addr_d = addr_q + ADDR_W'(1);
        if (state_q == ST_IDLE) begin
            wr_cfg_c.mode = mode_in;
            wr_cfg_c.seed = seed_in;
            wr_addr_d     = '0;
        end
    end

    ram_scrambler_config_writer_image u_wr_image (
        .mode_i (wr_cfg_c.mode),
        .seed_i (wr_cfg_c.seed),
        .addr_i (wr_addr_d),
        .byte_c (wr_byte_c)
    );

    ram_scrambler_config_writer_image u_vf_image (
        .mode_i (cfg_q.mode),
        .seed_i (cfg_q.seed),
        .addr_i (idx_q),
        .byte_c (exp_byte_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wren_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        cfg_q   <= wr_cfg_c;
                        verr_q  <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= wr_byte_c;
                        wren_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        wren_q <= 1'b0;
                        addr_q <= '0;
                        data_q <= '0;
                        idx_q  <= IDX_START;
                        if (VERIFY_EN) begin
                            state_q <= ST_VERIFY;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end else begin
                        addr_q <= wr_addr_d;
                        data_q <= wr_byte_c;
                    end
                end
                ST_VERIFY: begin
                    if (addr_q != LAST_ADDR) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    idx_q <= idx_q + ADDR_W'(1);
                    if (!idx_q[ADDR_W-1]) begin
                        if (q != exp_byte_c) begin
                            verr_q <= 1'b1;
                        end
                        if (idx_q == LAST_ADDR) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign address      = addr_q;
    assign data         = data_q;
    assign wren         = wren_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign verify_error = verr_q;

endmodule
